// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master block.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    TRANSFER,
    HOLD,
    DONE
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  // Width needed to count sclk edges 0..2*data_width inclusive.
  function automatic int edge_cnt_width(input int data_width);
    return $clog2(2 * data_width + 1);
  endfunction

endpackage

// File: rtl/spi_clock_divider.sv
// Half-period counter: tick marks the last system clock of each sclk half-period.
// Latency: tick is combinational from the count; first tick HalfPeriod cycles after clear.
// Backpressure: none; counts only while enable is high, clear wins over enable.
module spi_clock_divider import spi_pkg::*; #(
  parameter int HalfPeriod = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int CntW = (HalfPeriod > 1) ? $clog2(HalfPeriod) : 1;
  localparam logic [CntW-1:0] Last = CntW'(HalfPeriod - 1);

  logic [CntW-1:0] count;

  // Wrapping 0..HalfPeriod-1 counter, restarted whenever the FSM changes state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == Last) ? '0 : count + 1'b1;
    end
  end

  assign tick = enable && (count == Last);

endmodule

// File: rtl/spi_master.sv
// SPI master: one full-duplex MSB-first DataWidth-bit transfer per accepted start.
// Latency: busy for HalfPeriod*(2*DataWidth+2) cycles; rx_valid one cycle after that.
// Backpressure: start is only accepted in IDLE; starts while busy are dropped, not queued.
module spi_master import spi_pkg::*; #(
  parameter int DataWidth       = 8,
  parameter int NumberOfSlaves  = 1,
  parameter int HalfPeriod      = 2,
  parameter int SlaveIndexWidth = (NumberOfSlaves > 1) ? $clog2(NumberOfSlaves) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [SlaveIndexWidth-1:0] slave_index,
  input  logic                       cpol,
  input  logic                       cpha,
  input  logic [DataWidth-1:0]       tx_data,
  output logic [DataWidth-1:0]       rx_data,
  output logic                       rx_valid,
  output logic                       busy,
  output logic                       start_error,
  output logic                       sclk,
  output logic                       mosi,
  input  logic [NumberOfSlaves-1:0]  miso,
  output logic [NumberOfSlaves-1:0]  nss
);

  localparam int EdgeW = edge_cnt_width(DataWidth);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DataWidth);

  spi_state_e                 state, state_d;
  spi_mode_t                  mode;
  logic [SlaveIndexWidth-1:0] idx;
  logic [DataWidth-1:0]       tx_sh, rx_sh;
  logic [EdgeW-1:0]           edge_cnt, edge_nxt;
  logic                       tick, div_clear;
  logic                       idx_ok, accept;
  logic                       edge_go, edge_lead, do_sample, do_shift;

  assign idx_ok    = 32'(slave_index) < NumberOfSlaves;
  assign accept    = (state == IDLE) && start && idx_ok;
  assign busy      = (state == SETUP) || (state == TRANSFER) || (state == HOLD);
  assign div_clear = (state_d != state);

  spi_clock_divider #(.HalfPeriod(HalfPeriod)) u_div (
    .clock  (clock),
    .reset  (reset),
    .enable (busy),
    .clear  (div_clear),
    .tick   (tick)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic; the transfer ends one half-period after the final edge.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (accept) state_d = SETUP;
      SETUP:    if (tick) state_d = TRANSFER;
      TRANSFER: if (tick && (edge_cnt == LastEdge)) state_d = HOLD;
      HOLD:     if (tick) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Edge decode: the tick ending SETUP produces edge 1, odd edges lead, even edges trail.
  always_comb begin
    edge_nxt  = edge_cnt + 1'b1;
    edge_go   = tick && ((state == SETUP) || ((state == TRANSFER) && (edge_cnt != LastEdge)));
    edge_lead = edge_nxt[0];
    do_sample = edge_go && (edge_lead != mode.cpha);
    do_shift  = edge_go && !do_sample && (edge_nxt != LastEdge);
  end

  // Datapath: request latch, sclk generation, shift registers, selects and result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode        <= '0;
      idx         <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      edge_cnt    <= '0;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      nss         <= '1;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      start_error <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      start_error <= (state == IDLE) && start && !idx_ok;
      if (accept) begin
        mode     <= spi_mode_t'{cpol, cpha};
        idx      <= slave_index;
        rx_sh    <= '0;
        edge_cnt <= '0;
        sclk     <= cpol;
        nss      <= ~(NumberOfSlaves'(1) << slave_index);
        if (cpha) begin
          tx_sh <= tx_data;
        end else begin
          // Mode with cpha=0 presents the MSB before the first edge.
          mosi  <= tx_data[DataWidth-1];
          tx_sh <= tx_data << 1;
        end
      end
      if (edge_go) begin
        sclk     <= ~sclk;
        edge_cnt <= edge_nxt;
      end else if ((state == TRANSFER) && tick) begin
        sclk <= mode.cpol;
      end
      if (do_sample) rx_sh <= {rx_sh[DataWidth-2:0], miso[idx]};
      if (do_shift) begin
        mosi  <= tx_sh[DataWidth-1];
        tx_sh <= tx_sh << 1;
      end
      if ((state == HOLD) && tick) nss <= '1;
      if (state == DONE) begin
        rx_data  <= rx_sh;
        rx_valid <= 1'b1;
      end
    end
  end

  a_nss_onehot: assert property (@(posedge clock) disable iff (reset) $countones(~nss) <= 1);
  a_pulse_excl: assert property (@(posedge clock) disable iff (reset) !(rx_valid && start_error));

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: vector table of transfers plus reset, reject and back-to-back sequences.
// Latency: checks exact busy length and rx_valid timing against hand-computed values.
// Backpressure: checks that starts while busy are dropped and held starts chain back to back.
module tb_spi_master;

  localparam int DW  = 8;
  localparam int NS  = 4;
  localparam int SIW = 3;
  localparam int HP  = 2;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  // Main DUT: four slaves, index wide enough to express out-of-range values.
  logic           start, cpol, cpha;
  logic [SIW-1:0] slave_index;
  logic [DW-1:0]  tx_data, rx_data;
  logic           rx_valid, busy, start_error, sclk, mosi;
  logic [NS-1:0]  miso, nss;

  spi_master #(.DataWidth(DW), .NumberOfSlaves(NS), .HalfPeriod(HP), .SlaveIndexWidth(SIW)) u_dut (
    .clock(clock), .reset(reset), .start(start), .slave_index(slave_index),
    .cpol(cpol), .cpha(cpha), .tx_data(tx_data), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .start_error(start_error), .sclk(sclk), .mosi(mosi), .miso(miso), .nss(nss)
  );

  // Second DUT: single slave, fastest divider, miso looped back from mosi.
  logic          start_b, slave_index_b, cpol_b, cpha_b;
  logic [DW-1:0] tx_b, rx_b;
  logic          rx_valid_b, busy_b, err_b, sclk_b, mosi_b;
  logic [0:0]    miso_b, nss_b;
  assign miso_b = mosi_b;

  spi_master #(.DataWidth(DW), .NumberOfSlaves(1), .HalfPeriod(1)) u_b2b (
    .clock(clock), .reset(reset), .start(start_b), .slave_index(slave_index_b),
    .cpol(cpol_b), .cpha(cpha_b), .tx_data(tx_b), .rx_data(rx_b), .rx_valid(rx_valid_b),
    .busy(busy_b), .start_error(err_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .nss(nss_b)
  );

  // Behavioural slave: watches the bus on the falling system clock edge.
  logic [7:0] slv_resp, slv_tx, slv_rx;
  logic       slv_bit = 1'b1;
  logic [1:0] slv_sel;
  logic       tcpol, tcpha, loopback;
  logic       prev_nss = 1'b1, prev_sclk = 1'b0;
  logic       sel_nss;
  assign sel_nss = nss[slv_sel];

  always @(negedge clock) begin
    if (!sel_nss && prev_nss) begin
      slv_rx <= 8'h00;
      if (!tcpha) begin
        slv_bit <= slv_resp[7];
        slv_tx  <= slv_resp << 1;
      end else begin
        slv_tx <= slv_resp;
      end
    end else if (!sel_nss && (sclk != prev_sclk)) begin
      if ((sclk != tcpol) != tcpha) begin
        slv_rx <= {slv_rx[6:0], mosi};
      end else begin
        slv_bit <= slv_tx[7];
        slv_tx  <= slv_tx << 1;
      end
    end
    prev_nss  <= sel_nss;
    prev_sclk <= sclk;
  end

  always_comb begin
    miso = '1;
    if (loopback) miso[0] = mosi;
    else          miso[slv_sel] = slv_bit;
  end

  int rise_cnt = 0;
  always @(posedge sclk) rise_cnt <= rise_cnt + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic [2:0] idx;
    logic [7:0] tx;
    logic [7:0] resp;
    logic       lb;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t vecs[5];

  // Start one transfer and follow it until rx_valid or a 200-cycle budget.
  task automatic run_xfer(input vec_t v, output int lat, output int bcyc, output int rises,
                          output logic [3:0] lowmask, output int hot_err, output logic err_acc);
    int r0;
    @(negedge clock);
    cpol = v.cpol; cpha = v.cpha; slave_index = v.idx; tx_data = v.tx;
    slv_resp = v.resp; slv_sel = v.idx[1:0]; tcpol = v.cpol; tcpha = v.cpha; loopback = v.lb;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    r0 = rise_cnt; lat = 0; bcyc = 0; hot_err = 0;
    err_acc = start_error;
    lowmask = ~nss;
    if (busy) bcyc++;
    for (int k = 0; k < 200; k++) begin
      @(posedge clock); #1;
      lat++;
      if (rx_valid) break;
      if (busy) bcyc++;
      lowmask = lowmask | ~nss;
      if ($countones(~nss) > 1) hot_err++;
    end
    rises = rise_cnt - r0;
  endtask

  initial begin
    int lat, bcyc, rises, hot_err, nv, nhigh, k1, k2;
    logic [3:0] lowmask, m;
    logic err_acc;
    logic [7:0] r1, r2;
    logic [2:0] bad_idx[3];

    vecs[0] = '{1'b0, 1'b0, 3'd0, 8'hA5, 8'h00, 1'b1, 8'hA5};
    vecs[1] = '{1'b1, 1'b1, 3'd0, 8'hC3, 8'h3C, 1'b0, 8'h3C};
    vecs[2] = '{1'b0, 1'b0, 3'd2, 8'h5A, 8'h81, 1'b0, 8'h81};
    vecs[3] = '{1'b0, 1'b1, 3'd1, 8'h96, 8'h69, 1'b0, 8'h69};
    vecs[4] = '{1'b1, 1'b0, 3'd3, 8'h01, 8'hFE, 1'b0, 8'hFE};
    bad_idx[0] = 3'd4; bad_idx[1] = 3'd5; bad_idx[2] = 3'd7;

    start = 0; cpol = 0; cpha = 0; slave_index = 0; tx_data = 0;
    start_b = 0; slave_index_b = 0; cpol_b = 0; cpha_b = 0; tx_b = 0;
    slv_resp = 0; slv_sel = 0; tcpol = 0; tcpha = 0; loopback = 0;

    #1 reset = 1'b1;
    #2;
    check("rst_sclk", sclk, 1'b0);
    check("rst_mosi", mosi, 1'b0);
    check("rst_nss", nss, 4'hF);
    check("rst_busy", busy, 1'b0);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_start_error", start_error, 1'b0);
    check("rst_rx_data", rx_data, 8'h00);
    repeat (2) @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_xfer(vecs[i], lat, bcyc, rises, lowmask, hot_err, err_acc);
      check($sformatf("v%0d_rx_data", i), rx_data, vecs[i].exp_rx);
      check($sformatf("v%0d_slave_rx", i), slv_rx, vecs[i].tx);
      check($sformatf("v%0d_latency", i), lat, 37);
      check($sformatf("v%0d_busy_cycles", i), bcyc, 36);
      check($sformatf("v%0d_sclk_rises", i), rises, 8);
      check($sformatf("v%0d_nss_mask", i), lowmask, 4'b0001 << vecs[i].idx);
      check($sformatf("v%0d_nss_onehot", i), hot_err, 0);
      check($sformatf("v%0d_no_err", i), err_acc, 1'b0);
      check($sformatf("v%0d_sclk_idle", i), sclk, vecs[i].cpol);
      @(posedge clock); #1;
      check($sformatf("v%0d_valid_pulse", i), rx_valid, 1'b0);
    end

    // Reset in the middle of a mode-0 transfer while sclk is high.
    @(negedge clock);
    cpol = 0; cpha = 0; slave_index = 1; tx_data = 8'h77; slv_resp = 8'h11;
    slv_sel = 1; tcpol = 0; tcpha = 0; loopback = 0; start = 1;
    @(negedge clock);
    start = 0;
    for (int k = 0; k < 100; k++) begin
      if (sclk && busy) break;
      @(negedge clock);
    end
    check("midrst_reached", sclk && busy, 1'b1);
    reset = 1'b1;
    #1;
    check("midrst_nss", nss, 4'hF);
    check("midrst_sclk", sclk, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_rx_data", rx_data, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    nv = 0;
    for (int k = 0; k < 60; k++) begin
      @(posedge clock); #1;
      if (rx_valid || busy) nv++;
    end
    check("midrst_quiet", nv, 0);

    // Out-of-range slave indices are rejected with a single start_error pulse.
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      slave_index = bad_idx[i]; start = 1;
      @(posedge clock); #1;
      start = 0;
      check($sformatf("rej%0d_error", i), start_error, 1'b1);
      check($sformatf("rej%0d_busy", i), busy, 1'b0);
      check($sformatf("rej%0d_nss", i), nss, 4'hF);
      @(posedge clock); #1;
      check($sformatf("rej%0d_error_clr", i), start_error, 1'b0);
      check($sformatf("rej%0d_busy_after", i), busy, 1'b0);
    end

    // A start pulsed mid-transfer must be dropped.
    @(negedge clock);
    cpol = 0; cpha = 0; slave_index = 1; tx_data = 8'h3C; slv_resp = 8'h5D;
    slv_sel = 1; tcpol = 0; tcpha = 0; loopback = 0; start = 1;
    @(posedge clock); #1;
    start = 0;
    nv = 0; m = 4'h0;
    for (int k = 0; k < 100; k++) begin
      if (k == 10) begin start = 1; tx_data = 8'hFF; slave_index = 2; end
      if (k == 11) start = 0;
      @(posedge clock); #1;
      if (rx_valid) nv++;
      m = m | ~nss;
    end
    check("ign_valid_count", nv, 1);
    check("ign_rx_data", rx_data, 8'h5D);
    check("ign_nss_mask", m, 4'b0010);

    // Back-to-back with start held high on the HalfPeriod=1 instance.
    @(negedge clock);
    tx_b = 8'h3A; start_b = 1;
    @(posedge clock); #1;
    tx_b = 8'hC5;
    k1 = 0; k2 = 0; r1 = 0; r2 = 0; nhigh = 0;
    for (int k = 1; k <= 45; k++) begin
      @(posedge clock); #1;
      if (rx_valid_b) begin
        if (k1 == 0) begin k1 = k; r1 = rx_b; end
        else if (k2 == 0) begin k2 = k; r2 = rx_b; end
      end
      if (k <= 30 && nss_b[0]) nhigh++;
    end
    start_b = 0;
    check("b2b_first_latency", k1, 19);
    check("b2b_second_latency", k2, 39);
    check("b2b_first_rx", r1, 8'h3A);
    check("b2b_second_rx", r2, 8'hC5);
    check("b2b_nss_gap", nhigh >= 1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
